// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide issue controller.
// Holds the SPECIAL-opcode funct codes, the MD_Op encoding, the
// instruction class enum and the FSM state enum.
package muldiv_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Operation code presented to the unit
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  // HI/LO interaction class of an instruction
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_OP   = 2'd1,
    CLS_MT   = 2'd2,
    CLS_MF   = 2'd3
  } md_cls_e;

  // Tracking of the in-flight unit operation
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_issue_if.sv
// Handshake between the issue controller (master) and the
// multiply/divide unit (slave).
//   MD_D1/MD_D2  operands          MD_Op    operation
//   MD_Start     start pulse       MD_We    HI/LO write strobe
//   MD_HiLo      write target      MD_Busy  unit busy
//   MD_HI/MD_LO  unit result registers
interface muldiv_issue_if;
  import muldiv_pkg::*;

  logic [31:0] MD_D1;
  logic [31:0] MD_D2;
  md_op_e      MD_Op;
  logic        MD_Start;
  logic        MD_We;
  logic        MD_HiLo;
  logic        MD_Busy;
  logic [31:0] MD_HI;
  logic [31:0] MD_LO;

  modport master (
    output MD_D1, MD_D2, MD_Op, MD_Start, MD_We, MD_HiLo,
    input  MD_Busy, MD_HI, MD_LO
  );

  modport slave (
    input  MD_D1, MD_D2, MD_Op, MD_Start, MD_We, MD_HiLo,
    output MD_Busy, MD_HI, MD_LO
  );

endinterface

// File: rtl/muldiv_class_dec.sv
// Combinational decoder: instruction -> HI/LO class, unit op, HI/LO select.
//   instr  in   32-bit instruction word
//   cls    out  NONE / OP / MT / MF
//   op     out  MD_Op encoding (meaningful for class OP)
//   hilo   out  1 = HI, 0 = LO (meaningful for class MT and MF)
module muldiv_class_dec
  import muldiv_pkg::*;
(
  input  logic [31:0] instr,
  output md_cls_e     cls,
  output md_op_e      op,
  output logic        hilo
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_fields_s;

  assign opcode_s        = instr[31:26];
  assign funct_s         = instr[5:0];
  assign unused_fields_s = ^instr[25:6];

  // Classify SPECIAL-opcode HI/LO instructions; everything else is NONE
  always_comb begin
    cls  = CLS_NONE;
    op   = MD_MULTU;
    hilo = 1'b0;
    if (opcode_s == OPC_SPECIAL) begin
      case (funct_s)
        FN_MULT:  begin cls = CLS_OP; op = MD_MULT;  end
        FN_MULTU: begin cls = CLS_OP; op = MD_MULTU; end
        FN_DIV:   begin cls = CLS_OP; op = MD_DIV;   end
        FN_DIVU:  begin cls = CLS_OP; op = MD_DIVU;  end
        FN_MTHI:  begin cls = CLS_MT; hilo = 1'b1;   end
        FN_MTLO:  begin cls = CLS_MT; hilo = 1'b0;   end
        FN_MFHI:  begin cls = CLS_MF; hilo = 1'b1;   end
        FN_MFLO:  begin cls = CLS_MF; hilo = 1'b0;   end
        default:  begin cls = CLS_NONE;              end
      endcase
    end else begin
      cls = CLS_NONE;
    end
  end

endmodule

// File: rtl/muldiv_issue.sv
// Issue and hazard controller for the multiply/divide unit.
// Decodes the E-stage instruction into one Start or We pulse per
// instruction, stalls D while a HI/LO instruction would collide with an
// in-flight operation, and returns mfhi/mflo data to the E result mux.
//   Clk, Rst          clock, asynchronous active-high reset
//   D_Instr, E_Instr  D/E stage instructions
//   E_RS, E_RT        forwarded E operands
//   E_Hold, E_Flush   E frozen / E instruction killed
//   md                handshake to the unit (master side)
//   Stall             freeze F/D, bubble into E
//   E_MDOut, E_MDSel  mfhi/mflo data and its select
//   StallCnt          saturating count of stalled cycles
module muldiv_issue
  import muldiv_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            D_Instr,
  input  logic [31:0]            E_Instr,
  input  logic [31:0]            E_RS,
  input  logic [31:0]            E_RT,
  input  logic                   E_Hold,
  input  logic                   E_Flush,
  muldiv_issue_if.master         md,
  output logic                   Stall,
  output logic [31:0]            E_MDOut,
  output logic                   E_MDSel,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  md_cls_e   d_cls_s, e_cls_s;
  md_op_e    d_op_s, e_op_s;
  logic      d_hilo_s, e_hilo_s;
  logic      unused_d_dec_s;

  md_state_e state_q, state_d;
  logic      issued_q, issued_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic start_s;
  logic we_s;
  logic stall_s;

  muldiv_class_dec u_d_dec (.instr(D_Instr), .cls(d_cls_s), .op(d_op_s), .hilo(d_hilo_s));
  muldiv_class_dec u_e_dec (.instr(E_Instr), .cls(e_cls_s), .op(e_op_s), .hilo(e_hilo_s));

  // D only needs the class; op and select are not used there
  assign unused_d_dec_s = ^{d_op_s, d_hilo_s};

  // issued suppresses repeat pulses while E is frozen on the same instruction
  assign start_s = (e_cls_s == CLS_OP) & ~E_Flush & ~issued_q;
  assign we_s    = (e_cls_s == CLS_MT) & ~E_Flush & ~issued_q;

  // RUN keeps D stalled through the first cycle Busy is low, so a
  // following MF/MT/OP never enters E before the result lands
  assign stall_s = (d_cls_s != CLS_NONE) & (md.MD_Busy | (state_q == ST_RUN));

  assign md.MD_D1    = E_RS;
  assign md.MD_D2    = E_RT;
  assign md.MD_Op    = e_op_s;
  assign md.MD_Start = start_s;
  assign md.MD_We    = we_s;
  assign md.MD_HiLo  = (e_cls_s == CLS_MT) & e_hilo_s;

  assign Stall    = stall_s;
  assign E_MDSel  = (e_cls_s == CLS_MF);
  assign E_MDOut  = e_hilo_s ? md.MD_HI : md.MD_LO;
  assign StallCnt = stall_cnt_q;

  // FSM next state: follow the unit from Start until Busy drops, plus one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!md.MD_Busy) state_d = ST_DONE;
        else             state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // issued next value: set by a pulse under hold, cleared whenever E advances
  always_comb begin
    issued_d = issued_q;
    if (!E_Hold)               issued_d = 1'b0;
    else if (start_s || we_s)  issued_d = 1'b1;
    else                       issued_d = issued_q;
  end

  // Stall counter next value, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    else                                stall_cnt_d = stall_cnt_q;
  end

  // State registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      issued_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue: a small pipeline driver feeds
// instruction programs, a stand-in multiply/divide unit answers the
// handshake, and a scoreboard checks every Start / We / mfhi-mflo event
// against an architectural HI/LO model.
module tb_muldiv_issue;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 17;
  localparam int DIV_LAT = 43;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    int          hold;
    bit          flush;
  } prog_t;

  typedef struct {
    int          kind;   // 0 start, 1 write, 2 read
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        hilo;
    logic [31:0] data;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] D_Instr, E_Instr, E_RS, E_RT;
  logic        E_Hold, E_Flush;
  logic        Stall, E_MDSel;
  logic [31:0] E_MDOut;
  logic [31:0] StallCnt;
  logic        Stall4, E_MDSel4;
  logic [31:0] E_MDOut4;
  logic [3:0]  StallCnt4;

  int checks = 0;
  int errors = 0;
  int stall_seen;
  bit e_first;
  logic [31:0] ref_hi, ref_lo;
  exp_t  exp_q[$];
  prog_t prog_q[$];

  muldiv_issue_if md_if ();
  muldiv_issue_if md_if4 ();

  muldiv_issue #(.STALL_CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .D_Instr(D_Instr), .E_Instr(E_Instr), .E_RS(E_RS), .E_RT(E_RT),
    .E_Hold(E_Hold), .E_Flush(E_Flush), .md(md_if), .Stall(Stall), .E_MDOut(E_MDOut),
    .E_MDSel(E_MDSel), .StallCnt(StallCnt)
  );

  // Narrow-counter copy to observe saturation
  muldiv_issue #(.STALL_CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .D_Instr(D_Instr), .E_Instr(E_Instr), .E_RS(E_RS), .E_RT(E_RT),
    .E_Hold(E_Hold), .E_Flush(E_Flush), .md(md_if4), .Stall(Stall4), .E_MDOut(E_MDOut4),
    .E_MDSel(E_MDSel4), .StallCnt(StallCnt4)
  );

  always #5 Clk = ~Clk;

  // Architectural result of a HI/LO operation: {hi, lo}
  function automatic logic [63:0] arith(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      2'b00: p = ua * ub;
      2'b01: p = sa * sb;
      2'b10: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; p = {ur[31:0], uq[31:0]}; end
      2'b11: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; p = {sr[31:0], sq[31:0]}; end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  function automatic logic [1:0] fn_op(input logic [5:0] fn);
    case (fn)
      6'h18:   return 2'b01;
      6'h19:   return 2'b00;
      6'h1A:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Stand-in unit: Busy while Start or counting; results land on the last busy edge
  int unsigned busy_cnt;
  logic [31:0] u_hi, u_lo, pend_hi, pend_lo;
  assign md_if.MD_Busy  = md_if.MD_Start | (busy_cnt != 0);
  assign md_if.MD_HI    = u_hi;
  assign md_if.MD_LO    = u_lo;
  assign md_if4.MD_Busy = md_if.MD_Busy;
  assign md_if4.MD_HI   = u_hi;
  assign md_if4.MD_LO   = u_lo;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy_cnt <= 0; u_hi <= 32'd0; u_lo <= 32'd0; pend_hi <= 32'd0; pend_lo <= 32'd0;
    end else if (md_if.MD_Start) begin
      {pend_hi, pend_lo} <= arith(md_if.MD_Op, md_if.MD_D1, md_if.MD_D2);
      busy_cnt <= md_if.MD_Op[1] ? DIV_LAT : MUL_LAT;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin u_hi <= pend_hi; u_lo <= pend_lo; end
    end else if (md_if.MD_We) begin
      if (md_if.MD_HiLo) u_hi <= md_if.MD_D1;
      else               u_lo <= md_if.MD_D1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction entering E updates architectural HI/LO
  task automatic ref_enter(input prog_t e);
    exp_t ex;
    logic [63:0] r;
    ex = '{kind: 0, op: 2'b00, d1: e.rs, d2: e.rt, hilo: 1'b0, data: 32'd0};
    if (e.instr[31:26] == 6'd0) begin
      case (e.instr[5:0])
        6'h18, 6'h19, 6'h1A, 6'h1B: if (!e.flush) begin
          ex.kind = 0; ex.op = fn_op(e.instr[5:0]);
          exp_q.push_back(ex);
          r = arith(ex.op, e.rs, e.rt);
          ref_hi = r[63:32]; ref_lo = r[31:0];
        end
        6'h11: if (!e.flush) begin ex.kind = 1; ex.hilo = 1'b1; ex.data = e.rs; exp_q.push_back(ex); ref_hi = e.rs; end
        6'h13: if (!e.flush) begin ex.kind = 1; ex.hilo = 1'b0; ex.data = e.rs; exp_q.push_back(ex); ref_lo = e.rs; end
        6'h10: begin ex.kind = 2; ex.data = ref_hi; exp_q.push_back(ex); end
        6'h12: begin ex.kind = 2; ex.data = ref_lo; exp_q.push_back(ex); end
        default: ;
      endcase
    end
  endtask

  task automatic take(input int kind, input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic hilo, input logic [31:0] data);
    exp_t ex;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d with empty queue at %0t", kind, $time);
    end else begin
      ex = exp_q.pop_front();
      if (ex.kind != kind) begin
        errors++;
        $display("FAIL event_kind actual=%0d expected=%0d at %0t", kind, ex.kind, $time);
      end else if (kind == 0 && (op !== ex.op || d1 !== ex.d1 || d2 !== ex.d2)) begin
        errors++;
        $display("FAIL start actual op=%b d1=%h d2=%h expected op=%b d1=%h d2=%h", op, d1, d2, ex.op, ex.d1, ex.d2);
      end else if (kind == 1 && (hilo !== ex.hilo || d1 !== ex.data)) begin
        errors++;
        $display("FAIL write actual hilo=%b data=%h expected hilo=%b data=%h", hilo, d1, ex.hilo, ex.data);
      end else if (kind == 2 && data !== ex.data) begin
        errors++;
        $display("FAIL read actual=%h expected=%h at %0t", data, ex.data, $time);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (!Rst) begin
        if (md_if.MD_Start) take(0, md_if.MD_Op, md_if.MD_D1, md_if.MD_D2, 1'b0, 32'd0);
        if (md_if.MD_We)    take(1, 2'b00, md_if.MD_D1, 32'd0, md_if.MD_HiLo, 32'd0);
        if (E_MDSel && e_first) take(2, 2'b00, 32'd0, 32'd0, 1'b0, E_MDOut);
      end
    end
  end

  function automatic prog_t mk(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                               input logic [31:0] rt, input int hold, input bit flush);
    prog_t p;
    p.instr = {opc, 20'h00000, fn};
    p.rs = rs; p.rt = rt; p.hold = hold; p.flush = flush;
    return p;
  endfunction

  task automatic drive_nop();
    D_Instr = 32'd0; E_Instr = 32'd0; E_RS = 32'd0; E_RT = 32'd0;
    E_Hold = 1'b0; E_Flush = 1'b0; e_first = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    drive_nop();
    exp_q.delete();
    ref_hi = 32'd0; ref_lo = 32'd0; stall_seen = 0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Pipeline driver: Hold freezes D and E, Stall holds D and bubbles E
  task automatic run_prog(input int budget);
    prog_t d_ent, e_ent, nop;
    int    hold_left, cyc;
    bit    first, stl;
    nop = mk(6'd0, 6'd0, 32'd0, 32'd0, 0, 1'b0);
    d_ent = (prog_q.size() != 0) ? prog_q.pop_front() : nop;
    e_ent = nop; hold_left = 0; first = 1'b1; cyc = 0;
    while ((prog_q.size() != 0 || d_ent.instr != 32'd0 || e_ent.instr != 32'd0 || md_if.MD_Busy) && cyc < budget) begin
      @(negedge Clk);
      D_Instr = d_ent.instr; E_Instr = e_ent.instr; E_RS = e_ent.rs; E_RT = e_ent.rt;
      E_Hold  = (hold_left != 0);
      E_Flush = e_ent.flush && (hold_left == 0);
      e_first = first;
      #1;
      stl = Stall;
      if (stl) stall_seen++;
      @(posedge Clk);
      cyc++;
      if (hold_left != 0) begin
        hold_left--; first = 1'b0;
      end else if (stl) begin
        e_ent = nop; first = 1'b1;
      end else begin
        e_ent = d_ent;
        d_ent = (prog_q.size() != 0) ? prog_q.pop_front() : nop;
        first = 1'b1;
        ref_enter(e_ent);
        hold_left = e_ent.hold;
      end
    end
    chk("prog_budget", 64'(cyc < budget), 64'd1);
    repeat (3) begin @(negedge Clk); drive_nop(); end
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    prog_t p;
    int sel;
    Rst = 1'b1;
    drive_nop();
    ref_hi = 32'd0; ref_lo = 32'd0; stall_seen = 0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_start",   64'(md_if.MD_Start), 64'd0);
    chk("rst_we",      64'(md_if.MD_We),    64'd0);
    chk("rst_hilo",    64'(md_if.MD_HiLo),  64'd0);
    chk("rst_stall",   64'(Stall),          64'd0);
    chk("rst_mdsel",   64'(E_MDSel),        64'd0);
    chk("rst_mdout",   64'(E_MDOut),        64'd0);
    chk("rst_stallcnt",64'(StallCnt),       64'd0);
    Rst = 1'b0;

    // mult 3 * -2 with mflo right behind, then mfhi
    do_reset();
    prog_q.push_back(mk(6'd0, 6'h18, 32'd3, 32'hFFFFFFFE, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h12, 32'd0, 32'd0, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h10, 32'd0, 32'd0, 0, 1'b0));
    run_prog(200);
    chk("mult_stall_cycles", 64'(stall_seen), 64'd19);
    chk("mult_stallcnt",     64'(StallCnt),   64'd19);
    chk("stallcnt_saturate", 64'(StallCnt4),  64'd15);

    // divu 7/2
    do_reset();
    prog_q.push_back(mk(6'd0, 6'h1B, 32'd7, 32'd2, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h12, 32'd0, 32'd0, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h10, 32'd0, 32'd0, 0, 1'b0));
    run_prog(200);
    chk("divu_stall_cycles", 64'(stall_seen), 64'd45);

    // held mult pulses once; a later mult still starts
    do_reset();
    prog_q.push_back(mk(6'd0, 6'h18, 32'd11, 32'd13, 3, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h12, 32'd0, 32'd0, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h19, 32'd5, 32'd6, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h12, 32'd0, 32'd0, 0, 1'b0));
    run_prog(200);

    // flushed div: no start, no stall
    do_reset();
    prog_q.push_back(mk(6'd0, 6'h1A, 32'd100, 32'd7, 0, 1'b1));
    prog_q.push_back(mk(6'd0, 6'h12, 32'd0, 32'd0, 0, 1'b0));
    run_prog(200);
    chk("flush_no_stall", 64'(stall_seen), 64'd0);

    // mthi behind a busy mult must land after the result
    do_reset();
    prog_q.push_back(mk(6'd0, 6'h18, 32'd9, 32'd9, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h11, 32'h12345678, 32'd0, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h10, 32'd0, 32'd0, 0, 1'b0));
    prog_q.push_back(mk(6'd0, 6'h12, 32'd0, 32'd0, 0, 1'b0));
    run_prog(200);

    // reset in the middle of a div
    do_reset();
    p = mk(6'd0, 6'h1A, 32'd100, 32'd7, 0, 1'b0);
    @(negedge Clk);
    D_Instr = 32'h00000012; E_Instr = p.instr; E_RS = p.rs; E_RT = p.rt; e_first = 1'b1;
    ref_enter(p);
    for (int c = 2; c <= 9; c++) begin
      @(negedge Clk);
      E_Instr = 32'd0; E_RS = 32'd0; E_RT = 32'd0;
    end
    #1;
    chk("div_stall_before_rst", 64'(Stall), 64'd1);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("rst_mid_stall",    64'(Stall),    64'd0);
    chk("rst_mid_stallcnt", 64'(StallCnt), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("after_rst_stall", 64'(Stall), 64'd0);
    @(negedge Clk);
    #1;
    chk("after_rst_idle", 64'(Stall), 64'd0);

    // randomized instruction stream
    do_reset();
    for (int i = 0; i < 80; i++) begin
      logic [31:0] rs, rt;
      int hold;
      bit flush;
      sel = $urandom_range(0, 9);
      rs = $urandom; rt = $urandom;
      if (rt == 32'd0) rt = 32'd1;
      hold  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      flush = (hold == 0) && ($urandom_range(0, 5) == 0);
      case (sel)
        0, 1, 2: p = mk(6'd0, 6'(6'h18 + $urandom_range(0, 3)), rs, rt, hold, flush);
        3:       p = mk(6'd0, 6'h11, rs, rt, hold, flush);
        4:       p = mk(6'd0, 6'h13, rs, rt, hold, flush);
        5:       p = mk(6'd0, 6'h10, rs, rt, hold, flush);
        6:       p = mk(6'd0, 6'h12, rs, rt, hold, flush);
        7:       p = mk(6'd0, 6'h21, rs, rt, hold, flush);
        8:       p = mk(6'h23, 6'(6'h18 + $urandom_range(0, 3)), rs, rt, hold, flush);
        default: p = mk(6'h0D, 6'h10, rs, rt, hold, flush);
      endcase
      prog_q.push_back(p);
    end
    run_prog(8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
